// File: rtl/lsu_mem_stage_if.sv
// rtl/lsu_mem_stage_if.sv - memory request/acknowledge bus between the LSU and data memory
//
// Purpose : groups the single-outstanding req/ack memory bus of the load/store unit.
// Signals : mem_req   - request, held until ack or abort (master -> slave)
//           mem_we    - 1 = write
//           mem_addr  - word-aligned address
//           mem_wstrb - byte-lane write enables
//           mem_wdata - lane-replicated store data
//           mem_rdata - read data, valid while mem_ack=1 (slave -> master)
//           mem_ack   - request completes this cycle (slave -> master)
interface lsu_mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - RV32I load/store unit memory stage (IDLE/WAIT/RESP)
//
// Purpose : accepts one memory op from execute, checks width/alignment, runs one
//           req/ack transaction, and returns an extended load result, a store
//           completion, or an error pulse with cause and faulting address.
// Ports   : clk, rst          - clock, asynchronous active-high reset
//           ex_*_i / ex_ready_o - op from execute (accepted only in IDLE)
//           mem                - memory bus (master side)
//           wb_valid_o/wb_rd_o/wb_data_o - load writeback
//           st_done_o          - store completion pulse
//           err_o/err_cause_o/err_addr_o - abort pulse, 01 misaligned, 10 timeout, 11 illegal funct3
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic        ex_store_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [4:0]  ex_rd_i,
    lsu_mem_stage_if.master mem,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        st_done_o,
    output logic        err_o,
    output logic [1:0]  err_cause_o,
    output logic [31:0] err_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        R_LOAD  = 2'd0,
        R_STORE = 2'd1,
        R_ERR   = 2'd2
    } resp_t;

    // Counter value on the last cycle mem_req may be held without ack.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    resp_t       resp_q, resp_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [1:0]  err_cause_q, err_cause_d;

    logic        illegal;
    logic        misaligned;
    logic [31:0] rshift;
    logic [31:0] ld_ext;
    logic [3:0]  st_strb;
    logic [31:0] st_data;

    // 011/110/111 never legal; unsigned widths (100/101) only exist for loads.
    assign illegal    = (ex_funct3_i == 3'b011) ||
                        (ex_funct3_i[2] && (ex_funct3_i[1] || ex_store_i));
    assign misaligned = ((ex_funct3_i[1:0] == 2'b01) && ex_addr_i[0]) ||
                        ((ex_funct3_i == 3'b010) && (ex_addr_i[1:0] != 2'b00));

    // Lane extraction from the word returned by memory.
    assign rshift = mem.mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        ld_ext = rshift;
        case (funct3_q)
            3'b000:  ld_ext = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  ld_ext = {{16{rshift[15]}}, rshift[15:0]};
            3'b100:  ld_ext = {24'd0, rshift[7:0]};
            3'b101:  ld_ext = {16'd0, rshift[15:0]};
            default: ld_ext = rshift;
        endcase
    end

    // Store lanes: data is replicated so the strobe alone selects the bytes.
    always_comb begin
        st_strb = 4'b1111;
        st_data = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                st_strb = 4'b0001 << addr_q[1:0];
                st_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << addr_q[1:0];
                st_data = {2{wdata_q[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        resp_d      = resp_q;
        store_d     = store_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        err_addr_d  = err_addr_q;
        err_cause_d = err_cause_q;

        case (state_q)
            S_IDLE: begin
                if (ex_valid_i) begin
                    store_d  = ex_store_i;
                    funct3_d = ex_funct3_i;
                    addr_d   = ex_addr_i;
                    wdata_d  = ex_wdata_i;
                    rd_d     = ex_rd_i;
                    cnt_d    = 16'd0;
                    if (illegal) begin
                        state_d     = S_RESP;
                        resp_d      = R_ERR;
                        err_cause_d = 2'b11;
                        err_addr_d  = ex_addr_i;
                    end else if (misaligned) begin
                        state_d     = S_RESP;
                        resp_d      = R_ERR;
                        err_cause_d = 2'b01;
                        err_addr_d  = ex_addr_i;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Ack wins over a coincident timeout.
                if (mem.mem_ack) begin
                    state_d = S_RESP;
                    if (store_q) begin
                        resp_d = R_STORE;
                    end else begin
                        resp_d    = R_LOAD;
                        wb_data_d = ld_ext;
                        wb_rd_d   = rd_q;
                    end
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == TO_LAST)) begin
                    state_d     = S_RESP;
                    resp_d      = R_ERR;
                    err_cause_d = 2'b10;
                    err_addr_d  = addr_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            resp_q      <= R_LOAD;
            store_q     <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rd_q        <= 5'd0;
            cnt_q       <= 16'd0;
            wb_data_q   <= 32'd0;
            wb_rd_q     <= 5'd0;
            err_addr_q  <= 32'd0;
            err_cause_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            resp_q      <= resp_d;
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            err_addr_q  <= err_addr_d;
            err_cause_q <= err_cause_d;
        end
    end

    // All strobes and bus fields decode from the state register, so an
    // asynchronous reset drops them immediately.
    assign ex_ready_o    = (state_q == S_IDLE);
    assign mem.mem_req   = (state_q == S_WAIT);
    assign mem.mem_we    = (state_q == S_WAIT) && store_q;
    assign mem.mem_addr  = (state_q == S_WAIT) ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem.mem_wstrb = ((state_q == S_WAIT) && store_q) ? st_strb : 4'd0;
    assign mem.mem_wdata = ((state_q == S_WAIT) && store_q) ? st_data : 32'd0;

    assign wb_valid_o  = (state_q == S_RESP) && (resp_q == R_LOAD);
    assign st_done_o   = (state_q == S_RESP) && (resp_q == R_STORE);
    assign err_o       = (state_q == S_RESP) && (resp_q == R_ERR);
    assign wb_rd_o     = wb_rd_q;
    assign wb_data_o   = wb_data_q;
    assign err_cause_o = err_cause_q;
    assign err_addr_o  = err_addr_q;

endmodule
